block_ram_multi_read: RTL



---
 rtl/block_ram_multi_read.sv | 132 +++++++++++++
 1 files changed

// File: rtl/block_ram_multi_read.sv
// block_ram_multi_read
//   Byte-enabled single-write, multi-read block RAM. Each read port owns a
//   full replica of the storage; every replica sees every write, so ports
//   never contend. Read latency is 1 (stage-1 register drives the outputs)
//   or 2 (an extra output register behind stage 1).
//
//   Optional feature macro: BRAM_RD_FORWARD_EN
//     defined   -> write-first on a same-address read/write collision
//                  (written lanes are forwarded into stage 1)
//     undefined -> read-first (stage 1 captures the pre-write word)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (clears outputs/valids only)
//   wr_en     write strobe
//   wr_be     per-lane write enable, DATA_WIDTH/BYTE_WIDTH bits
//   wr_addr   write address
//   wr_data   write data
//   rd_en     per-port read strobe, bit p = port p
//   rd_addr   flat read address bus, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data   flat read data bus, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   rd_valid  per-port one-cycle valid pulse per completed read
module block_ram_multi_read #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    BYTE_WIDTH   = 8,
  parameter int    DEPTH        = 2**16,
  parameter int    NUM_RD       = 2,
  parameter int    READ_LATENCY = 1,
  parameter string RAM_STYLE    = "auto",
  localparam int   ADDR_WIDTH   = $clog2(DEPTH),
  localparam int   NUM_BE       = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [NUM_BE-1:0]            wr_be,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_valid
);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("block_ram_multi_read: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("block_ram_multi_read: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (NUM_RD < 1 || NUM_RD > 8) begin : g_bad_ports
    $error("block_ram_multi_read: NUM_RD must be 1..8");
  end
  if (RAM_STYLE == "") begin : g_bad_style
    $error("block_ram_multi_read: RAM_STYLE must not be empty");
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;

    assign addr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

    // Storage is deliberately not reset; only writes are blocked in reset.
    always_ff @(posedge clk) begin
      if (wr_en && rst_n) begin
        for (int i = 0; i < NUM_BE; i++) begin
          if (wr_be[i]) begin
            mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end

`ifdef BRAM_RD_FORWARD_EN
    // Same-edge collision: enabled lanes come from the write bus.
    always_comb begin
      rd_word = mem[addr];
      if (wr_en && (addr == wr_addr)) begin
        for (int i = 0; i < NUM_BE; i++) begin
          if (wr_be[i]) begin
            rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
`else
    // Nonblocking write ordering gives read-first on a collision.
    assign rd_word = mem[addr];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_data  <= '0;
        s1_valid <= 1'b0;
      end else begin
        s1_valid <= rd_en[p];
        if (rd_en[p]) begin
          s1_data <= rd_word;
        end
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] out_data;
      logic                  out_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_data  <= '0;
          out_valid <= 1'b0;
        end else begin
          out_valid <= s1_valid;
          if (s1_valid) begin
            out_data <= s1_data;
          end
        end
      end

      assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = out_data;
      assign rd_valid[p]                         = out_valid;
    end else begin : g_lat1
      assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = s1_data;
      assign rd_valid[p]                         = s1_valid;
    end
  end

endmodule
